// File: rtl/crypto_trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : crypto_trng_pkg
//  Brief   : Shared widths and sequencer state encoding for the TRNG AES-CTR path
//  Revision: 1.0  initial release
// ============================================================================
package crypto_trng_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int OUT_W         = 32;
    localparam int WORDS_PER_BLK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } ctr_state_e;

endpackage
`default_nettype wire

// File: rtl/trng_blk_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : trng_blk_serializer
//  Brief   : Holds one 128-bit block and drains it MSW-first over valid/ready
//  Revision: 1.0  initial release
// ============================================================================
module trng_blk_serializer
    import crypto_trng_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [AES_BLK_W-1:0] i_blk,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [OUT_W-1:0]     o_data,
    output logic                 o_last_acc
);

    localparam int c_idx_w = $clog2(WORDS_PER_BLK);

    logic [AES_BLK_W-1:0] r_buf;
    logic [c_idx_w-1:0]   r_widx;
    logic                 r_valid;
    logic                 w_accept;

    assign w_accept   = r_valid & i_ready;
    assign o_last_acc = w_accept && (r_widx == c_idx_w'(WORDS_PER_BLK - 1));
    assign o_valid    = r_valid;
    assign o_data     = r_buf[AES_BLK_W-1 -: OUT_W];

    // Shifting out the consumed word also zeroes it, so no keystream lingers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf   <= '0;
            r_widx  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_buf   <= '0;
            r_widx  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_blk;
            r_widx  <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_buf  <= {r_buf[AES_BLK_W-OUT_W-1:0], {OUT_W{1'b0}}};
            r_widx <= r_widx + 1'b1;
            if (o_last_acc) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_aes_ctr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : trng_aes_ctr_ctrl
//  Brief   : AES-128 counter-mode sequencer with reseed limit and cipher watchdog
//  Revision: 1.0  initial release
// ============================================================================
module trng_aes_ctr_ctrl
    import crypto_trng_pkg::*;
#(
    parameter logic [15:0] RESEED_MAX = 16'hFFFF,
    parameter logic [7:0]  WDOG_CYC   = 8'd32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 seed_we,
    input  logic [AES_BLK_W-1:0] seed_key,
    input  logic [AES_BLK_W-1:0] seed_v,
    input  logic                 enable,
    output logic                 aes_ld,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic [AES_BLK_W-1:0] aes_text_in,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_text_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 busy,
    output logic                 reseed_req,
    output logic                 err_timeout
);

    ctr_state_e           r_state;
    logic                 r_ld;
    logic [AES_BLK_W-1:0] r_key;
    logic [AES_BLK_W-1:0] r_v;
    logic [15:0]          r_count;
    logic                 r_seeded;
    logic                 r_reseed;
    logic                 r_err;
    logic [7:0]           r_wdog;
    logic                 w_start_ok;
    logic                 w_load;
    logic                 w_last_acc;

    assign w_start_ok = enable & r_seeded & ~r_reseed & ~r_err;
    assign w_load     = (r_state == WAIT) & aes_done & ~seed_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_ld     <= 1'b0;
            r_key    <= '0;
            r_v      <= '0;
            r_count  <= '0;
            r_seeded <= 1'b0;
            r_reseed <= 1'b0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
        end else if (seed_we) begin
            r_state  <= IDLE;
            r_ld     <= 1'b0;
            r_key    <= seed_key;
            r_v      <= seed_v;
            r_count  <= '0;
            r_seeded <= 1'b1;
            r_reseed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state <= START;
                        r_ld    <= 1'b1;
                    end
                end
                START: begin
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (aes_done) begin
                        r_v     <= r_v + 128'd1;
                        r_state <= DRAIN;
                        if (r_count != RESEED_MAX) begin
                            r_count <= r_count + 16'd1;
                        end
                    end else if (r_wdog == WDOG_CYC - 8'd1) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                DRAIN: begin
                    if (w_last_acc) begin
                        if (r_count == RESEED_MAX) begin
                            r_reseed <= 1'b1;
                            r_state  <= IDLE;
                        end else if (enable) begin
                            r_state <= START;
                            r_ld    <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    trng_blk_serializer u_ser (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (seed_we),
        .i_load     (w_load),
        .i_blk      (aes_text_out),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_last_acc (w_last_acc)
    );

    assign aes_ld      = r_ld;
    assign aes_key     = r_key;
    assign aes_text_in = r_v;
    assign busy        = (r_state != IDLE);
    assign reseed_req  = r_reseed;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_trng_aes_ctr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_trng_aes_ctr_ctrl
//  Brief   : Bench for trng_aes_ctr_ctrl with a behavioural AES-128 cipher model
//  Revision: 1.0  initial release
// ============================================================================
module tb_trng_aes_ctr_ctrl;

    localparam logic [15:0] RMAX = 16'd2;
    localparam logic [7:0]  WDOG = 8'd32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         seed_we = 1'b0;
    logic [127:0] seed_key = '0;
    logic [127:0] seed_v = '0;
    logic         enable = 1'b0;
    logic         aes_ld;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_done = 1'b0;
    logic [127:0] aes_text_out = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         busy;
    logic         reseed_req;
    logic         err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]   sbox_t [0:255];
    int           stub_lat = 3;
    bit           stub_hang = 1'b0;
    int           stub_cnt = 0;
    logic [127:0] stub_k, stub_pt;
    logic [127:0] ld_pts [$];
    int           ld_cyc [$];
    logic [31:0]  got [$];
    bit           rand_rdy = 1'b0;
    bit           p_stall = 1'b0;
    logic [31:0]  p_data = '0;

    trng_aes_ctr_ctrl #(.RESEED_MAX(RMAX), .WDOG_CYC(WDOG)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .seed_we      (seed_we),
        .seed_key     (seed_key),
        .seed_v       (seed_v),
        .enable       (enable),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .reseed_req   (reseed_req),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference (FIPS-197) ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0]  inv = 8'h01;
        logic [7:0]  s = 8'h63;
        logic [15:0] d;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        for (int i = 0; i < 5; i++) begin
            d = {inv, inv} << i;
            s = s ^ d[15:8];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [127:0] rk, res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = sbox_t[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
                end
            end
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Cipher stand-in: done arrives stub_lat cycles after the ld cycle; a new ld supersedes.
    always @(negedge clk) begin
        aes_done = 1'b0;
        if (!rstn) begin
            stub_cnt = 0;
        end else if (aes_ld) begin
            ld_pts.push_back(aes_text_in);
            ld_cyc.push_back(cyc);
            stub_k   = aes_key;
            stub_pt  = aes_text_in;
            stub_cnt = stub_hang ? 0 : stub_lat;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                aes_done     = 1'b1;
                aes_text_out = aes_enc(stub_k, stub_pt);
            end
        end
    end

    // Stream monitor: records accepted words and checks stall stability.
    always @(negedge clk) begin
        if (rstn) begin
            if (p_stall) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === p_data) else begin
                    failures++;
                    $error("FAIL stall_hold observed=%b/%h expected=1/%h", out_valid, out_data, p_data);
                end
            end
            if (out_valid && out_ready && !seed_we) got.push_back(out_data);
            p_stall = out_valid && !out_ready && !seed_we;
            p_data  = out_data;
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_seed(input logic [127:0] k, input logic [127:0] v);
        seed_key = k;
        seed_v   = v;
        seed_we  = 1'b1;
        tick();
        seed_we  = 1'b0;
    endtask

    task automatic clear_logs();
        got.delete();
        ld_pts.delete();
        ld_cyc.delete();
    endtask

    task automatic wait_words(input int n, input int budget);
        int i = 0;
        while (got.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk("wait_words", 128'(got.size() >= n), 128'd1);
    endtask

    task automatic wait_ld(input int budget);
        int i = 0;
        while (!aes_ld && i < budget) begin
            tick();
            i++;
        end
        chk("wait_ld", 128'(aes_ld), 128'd1);
    endtask

    // Keystream for (k, v) is AES_k(v), AES_k(v+1), ... each split MSW first.
    task automatic check_stream(input string tag, input logic [127:0] k, input logic [127:0] v, input int nblk);
        logic [127:0] ct;
        chk({tag, "_count"}, 128'(got.size()), 128'(4 * nblk));
        for (int b = 0; b < nblk; b++) begin
            ct = aes_enc(k, v + 128'(b));
            for (int w = 0; w < 4; w++)
                chk($sformatf("%s_b%0d_w%0d", tag, b, w), 128'(got[4*b+w]), 128'(ct[127-32*w -: 32]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld"}, 128'(aes_ld), 128'd0);
        chk({tag, "_key"}, aes_key, 128'd0);
        chk({tag, "_text"}, aes_text_in, 128'd0);
        chk({tag, "_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_data"}, 128'(out_data), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_reseed"}, 128'(reseed_req), 128'd0);
        chk({tag, "_err"}, 128'(err_timeout), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] ka, kb, va, vb, ct;
        int n;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        // Unseeded: enable alone must not start the cipher.
        enable = 1'b1;
        repeat (5) tick();
        chk("unseeded_no_ld", 128'(ld_pts.size()), 128'd0);
        chk("unseeded_busy", 128'(busy), 128'd0);

        // FIPS-197 vector, then reseed limit of two blocks.
        out_ready = 1'b1;
        clear_logs();
        ka = 128'h000102030405060708090a0b0c0d0e0f;
        va = 128'h00112233445566778899aabbccddeeff;
        do_seed(ka, va);
        chk("t1_key", aes_key, ka);
        wait_words(8, 200);
        repeat (10) tick();
        chk("t1_w0", 128'(got[0]), 128'h69c4e0d8);
        chk("t1_w1", 128'(got[1]), 128'h6a7b0430);
        chk("t1_w2", 128'(got[2]), 128'hd8cdb780);
        chk("t1_w3", 128'(got[3]), 128'h70b4c55a);
        check_stream("t1", ka, va, 2);
        chk("t1_next_v", ld_pts[1], 128'h00112233445566778899aabbccddef00);
        chk("t1_period", 128'(ld_cyc[1] - ld_cyc[0]), 128'(stub_lat + 5));
        chk("t1_ld_count", 128'(ld_pts.size()), 128'd2);
        chk("t1_reseed", 128'(reseed_req), 128'd1);
        chk("t1_busy", 128'(busy), 128'd0);

        // Counter wrap.
        clear_logs();
        kb = rnd128();
        do_seed(kb, '1);
        chk("t2_reseed_clr", 128'(reseed_req), 128'd0);
        wait_words(8, 200);
        repeat (10) tick();
        chk("t2_v0", ld_pts[0], '1);
        chk("t2_v1", ld_pts[1], 128'd0);
        check_stream("t2", kb, '1, 2);

        // Random back-pressure and cipher latency.
        rand_rdy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            stub_lat = $urandom_range(1, 12);
            clear_logs();
            ka = rnd128();
            va = rnd128();
            do_seed(ka, va);
            wait_words(8, 600);
            repeat (10) tick();
            check_stream($sformatf("t4_s%0d", s), ka, va, 2);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        // Abort during WAIT; the stale done must be ignored.
        stub_lat = 10;
        clear_logs();
        do_seed(rnd128(), rnd128());
        wait_ld(20);
        repeat (3) tick();
        enable = 1'b0;
        ka = rnd128();
        va = rnd128();
        do_seed(ka, va);
        chk("t5a_busy", 128'(busy), 128'd0);
        chk("t5a_valid", 128'(out_valid), 128'd0);
        repeat (15) tick();
        chk("t5a_stale_words", 128'(got.size()), 128'd0);
        chk("t5a_stale_valid", 128'(out_valid), 128'd0);
        clear_logs();
        enable = 1'b1;
        wait_words(8, 300);
        repeat (10) tick();
        check_stream("t5a", ka, va, 2);

        // Abort while word 2 of a block is presented.
        stub_lat = 4;
        out_ready = 1'b0;
        clear_logs();
        kb = rnd128();
        vb = rnd128();
        do_seed(kb, vb);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        enable = 1'b0;
        ka = rnd128();
        va = rnd128();
        do_seed(ka, va);
        chk("t5b_valid", 128'(out_valid), 128'd0);
        chk("t5b_busy", 128'(busy), 128'd0);
        ct = aes_enc(kb, vb);
        chk("t5b_count", 128'(got.size()), 128'd2);
        chk("t5b_w0", 128'(got[0]), 128'(ct[127:96]));
        chk("t5b_w1", 128'(got[1]), 128'(ct[95:64]));
        clear_logs();
        out_ready = 1'b1;
        enable = 1'b1;
        wait_words(8, 300);
        repeat (10) tick();
        check_stream("t5b", ka, va, 2);

        // Done arriving on the last allowed watchdog cycle is still accepted.
        stub_lat = 32;
        clear_logs();
        ka = rnd128();
        va = rnd128();
        do_seed(ka, va);
        wait_words(8, 300);
        repeat (10) tick();
        check_stream("t6_lat32", ka, va, 2);
        chk("t6_lat32_err", 128'(err_timeout), 128'd0);

        // Hung cipher: err rises WDOG cycles after the ld pulse ends, then no further ld.
        stub_hang = 1'b1;
        clear_logs();
        do_seed(rnd128(), rnd128());
        wait_ld(20);
        n = 0;
        while (!err_timeout && n < 100) begin
            tick();
            n++;
        end
        chk("t6_wdog_cycles", 128'(n), 128'(32'(WDOG) + 1));
        chk("t6_busy", 128'(busy), 128'd0);
        repeat (50) tick();
        chk("t6_no_more_ld", 128'(ld_pts.size()), 128'd1);
        chk("t6_err_sticky", 128'(err_timeout), 128'd1);
        do_seed('0, rnd128());
        chk("t6_err_clr", 128'(err_timeout), 128'd0);

        // Asynchronous reset while waiting on the cipher.
        wait_ld(20);
        repeat (5) tick();
        chk("t6_in_wait", 128'(busy), 128'd1);
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
